// File: rtl/line_track_filter_if.sv
// Signal bundle between a line-tracker sensor array and its debounce filter.
interface line_track_filter_if #(
   parameter int NUM_CH = 3
);
   logic [NUM_CH-1:0] track;
   logic [NUM_CH-1:0] detect_road;
   logic              road_change;
   logic              line_lost;
   logic [1:0]        last_side;

   modport master (
      output track,
      input  detect_road, road_change, line_lost, last_side
   );

   modport slave (
      input  track,
      output detect_road, road_change, line_lost, last_side
   );
endinterface

// File: rtl/line_track_filter.sv
// Line-tracker front end: synchronises and debounces each sensor channel, flags changes,
// detects a lost line and remembers which side the line was last seen on.
module line_track_filter #(
   parameter int NUM_CH     = 3,
   parameter int STABLE_CYC = 4,
   parameter int LOST_CYC   = 1000,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic               clk,
   input  logic               reset,
   line_track_filter_if.slave bus
);
   localparam int CW = $clog2(STABLE_CYC + 1);
   localparam int LW = $clog2(LOST_CYC + 1);
   localparam int C  = (NUM_CH - 1) / 2;

   localparam logic [NUM_CH-1:0] POL         = {NUM_CH{ACTIVE_LOW}};
   localparam logic [CW-1:0]     STABLE_LAST = CW'(STABLE_CYC - 1);
   localparam logic [LW-1:0]     LOST_MAX    = LW'(LOST_CYC);
   // Channels at or right of centre, and strictly right of centre.
   localparam logic [NUM_CH-1:0] MASK_LE_C   = NUM_CH'((1 << (C + 1)) - 1);
   localparam logic [NUM_CH-1:0] MASK_LT_C   = NUM_CH'((1 << C) - 1);

   localparam logic [1:0] SIDE_LEFT   = 2'b10;
   localparam logic [1:0] SIDE_RIGHT  = 2'b01;
   localparam logic [1:0] SIDE_CENTRE = 2'b11;

   logic [NUM_CH-1:0]         r_sync1;
   logic [NUM_CH-1:0]         r_sync2;
   logic [NUM_CH-1:0]         w_s;
   logic [NUM_CH-1:0]         r_f;
   logic [NUM_CH-1:0]         w_f_next;
   logic [NUM_CH-1:0][CW-1:0] r_cnt;
   logic [NUM_CH-1:0][CW-1:0] w_cnt_next;
   logic [LW-1:0]             r_lost_cnt;
   logic [LW-1:0]             w_lost_next;
   logic [1:0]                w_side;
   logic                      r_road_change;
   logic                      r_line_lost;
   logic [1:0]                r_last_side;

   // Synchroniser flops reset to the raw "no line" level so the normalised sample reads 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync1 <= POL;
         r_sync2 <= POL;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
         r_sync1 <= bus.track;
         r_sync2 <= r_sync1;
      end
   end

   assign w_s = r_sync2 ^ POL;

   always_comb begin
      // NOTE: defaults before any branch keep this block free of inferred latches.
      w_f_next   = r_f;
      w_cnt_next = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (w_s[i] != r_f[i]) begin
            if (r_cnt[i] == STABLE_LAST) begin
               w_f_next[i] = w_s[i];
            end else begin
               w_cnt_next[i] = r_cnt[i] + CW'(1);
            end
         end
      end
   end

   always_comb begin
      w_lost_next = r_lost_cnt;
      if (r_f != '0) begin
         w_lost_next = '0;
      end else if (r_lost_cnt != LOST_MAX) begin
         w_lost_next = r_lost_cnt + LW'(1);
      end
   end

   // Only consulted while some channel is set, so the all-zero pattern never matters here.
   always_comb begin
      w_side = SIDE_CENTRE;
      if ((r_f & MASK_LE_C) == '0) begin
         w_side = SIDE_LEFT;
      end else if ((r_f & ~MASK_LT_C) == '0) begin
         w_side = SIDE_RIGHT;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt         <= '0;
         r_f           <= '0;
         r_road_change <= 1'b0;
         r_lost_cnt    <= '0;
         r_line_lost   <= 1'b0;
         r_last_side   <= SIDE_CENTRE;
      end else begin
         r_cnt         <= w_cnt_next;
         r_f           <= w_f_next;
         r_road_change <= (w_f_next != r_f);
         r_lost_cnt    <= w_lost_next;
         r_line_lost   <= (w_lost_next == LOST_MAX);
         if (r_f != '0) begin
            r_last_side <= w_side;
         end
      end
   end

   assign bus.detect_road = r_f;
   assign bus.road_change = r_road_change;
   assign bus.line_lost   = r_line_lost;
   assign bus.last_side   = r_last_side;

endmodule
